// File: rtl/buzzer_seq.sv
// Avalon-MM programmable beeper: tone half-period, on/off gate length and beep count.
// Optional completion interrupt when BUZZER_SEQ_IRQ_EN is defined.
module buzzer_seq #(
  parameter int DIV_W  = 16,
  parameter int GATE_W = 24,
  parameter int CNT_W  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        buzz_out,
  output logic        irq
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;

  logic [1:0]        state;
  logic [DIV_W-1:0]  half_period;
  logic [GATE_W-1:0] gate_len;
  logic [CNT_W-1:0]  beep_count;
  logic [DIV_W-1:0]  tone_cnt;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  beeps_left;
  logic              done;
  logic              irq_mask;

  logic wr, ctrl_wr, start_req, stop_req, clr_req;
  logic tone_hit, gate_hit, last_beep, busy;
  logic unused_bits;

  assign wr        = chipselect & ~write_n;
  assign ctrl_wr   = wr && (address == 2'd0);
  assign start_req = ctrl_wr & writedata[0];
  assign stop_req  = ctrl_wr & writedata[1];
  assign clr_req   = ctrl_wr & writedata[2];
  // Equality compares: a counter already past a newly written limit wraps.
  assign tone_hit  = (tone_cnt == half_period);
  assign gate_hit  = (gate_cnt == gate_len);
  assign last_beep = (beep_count != '0) && (beeps_left == CNT_W'(1));
  assign busy      = (state != S_IDLE);
  assign unused_bits = &{1'b0, writedata};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      buzz_out    <= 1'b0;
      done        <= 1'b0;
      tone_cnt    <= '0;
      gate_cnt    <= '0;
      beeps_left  <= '0;
      half_period <= DIV_W'(12499);
      gate_len    <= GATE_W'(4999999);
      beep_count  <= CNT_W'(1);
    end else begin
      if (wr && address == 2'd1) half_period <= writedata[DIV_W-1:0];
      if (wr && address == 2'd2) gate_len    <= writedata[GATE_W-1:0];
      if (wr && address == 2'd3) beep_count  <= writedata[CNT_W-1:0];

      if (!enable || stop_req) begin
        state    <= S_IDLE;
        buzz_out <= 1'b0;
        tone_cnt <= '0;
        gate_cnt <= '0;
        if (clr_req) done <= 1'b0;
      end else if (start_req) begin
        state      <= S_ON;
        buzz_out   <= 1'b1;
        tone_cnt   <= '0;
        gate_cnt   <= '0;
        beeps_left <= beep_count;
        done       <= 1'b0;
      end else begin
        if (clr_req) done <= 1'b0;
        case (state)
          S_ON: begin
            if (gate_hit) begin
              state    <= S_OFF;
              buzz_out <= 1'b0;
              gate_cnt <= '0;
              tone_cnt <= '0;
            end else begin
              gate_cnt <= gate_cnt + 1'b1;
              if (tone_hit) begin
                buzz_out <= ~buzz_out;
                tone_cnt <= '0;
              end else begin
                tone_cnt <= tone_cnt + 1'b1;
              end
            end
          end
          S_OFF: begin
            if (gate_hit) begin
              gate_cnt <= '0;
              tone_cnt <= '0;
              // Setting done here overrides a same-cycle clear above.
              if (last_beep) begin
                state <= S_IDLE;
                done  <= 1'b1;
              end else begin
                state    <= S_ON;
                buzz_out <= 1'b1;
                if (beep_count != '0) beeps_left <= beeps_left - 1'b1;
              end
            end else begin
              gate_cnt <= gate_cnt + 1'b1;
            end
          end
          default: begin
            state    <= S_IDLE;
            buzz_out <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef BUZZER_SEQ_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (ctrl_wr) irq_mask <= writedata[3];
      irq <= done & irq_mask;
    end
  end
`else
  assign irq_mask = 1'b0;
  assign irq      = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: begin
        readdata[0]           = busy;
        readdata[1]           = done;
        readdata[3]           = irq_mask;
        readdata[8 +: CNT_W]  = beeps_left;
      end
      2'd1:    readdata[DIV_W-1:0]  = half_period;
      2'd2:    readdata[GATE_W-1:0] = gate_len;
      default: readdata[CNT_W-1:0]  = beep_count;
    endcase
  end

endmodule

// File: tb/tb_buzzer_seq.sv
// Self-checking bench for buzzer_seq: register table, directed corner sequences,
// and randomized beep programs checked against a timing-arithmetic reference model.
module tb_buzzer_seq;

`ifdef BUZZER_SEQ_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif
  localparam logic [31:0] MASK_RB = IRQ_ON ? 32'h8 : 32'h0;

  logic        clk = 1'b0;
  logic        reset, enable, chipselect, write_n;
  logic [1:0]  address;
  logic [31:0] writedata, readdata;
  logic        buzz_out, irq;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  buzzer_seq dut (
    .clk(clk), .reset(reset), .enable(enable), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .buzz_out(buzz_out), .irq(irq)
  );

  typedef struct {
    logic        do_wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // All tasks start and end at a falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; address = 2'd0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1 d = readdata;
    chipselect = 1'b0;
  endtask

  // Expected behaviour k cycles after the start edge, from beat arithmetic alone.
  function automatic void model(input int h, input int g, input int bc, input int k,
                                output logic eb, output logic [31:0] es);
    int len, beat, bl;
    logic busy, done;
    len  = g + 1;
    beat = k / len;
    if (bc != 0 && k >= 2 * bc * len) begin
      eb = 1'b0; busy = 1'b0; done = 1'b1; bl = 1;
    end else begin
      busy = 1'b1; done = 1'b0;
      eb = (beat % 2 == 0) && (((k % len) / (h + 1)) % 2 == 0);
      bl = (bc == 0) ? 0 : bc - beat / 2;
    end
    es = (32'(bl) << 8) | (32'(done) << 1) | 32'(busy);
  endfunction

  task automatic check_from(input int h, input int g, input int bc, input int k0, input int n);
    logic eb;
    logic [31:0] es, st;
    for (int k = k0; k < k0 + n; k++) begin
      model(h, g, bc, k, eb, es);
      chk("buzz_out", 32'(buzz_out), 32'(eb));
      rd(2'd0, st);
      chk("status", st, es);
      chk("irq_idle", 32'(irq), 32'h0);
      step(1);
    end
  endtask

  task automatic program_start(input int h, input int g, input int bc);
    wr(2'd1, 32'(h)); wr(2'd2, 32'(g)); wr(2'd3, 32'(bc)); wr(2'd0, 32'h1);
  endtask

  initial begin
    vec_t vecs[$];
    logic [31:0] d;
    int h, g, bc, n;

    reset = 1'b1; enable = 1'b1; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = '0;
    step(3);
    reset = 1'b0;
    step(1);
    chk("reset_buzz", 32'(buzz_out), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);

    // Register map table: reset values, width truncation, CTRL corner writes.
    vecs.push_back('{1'b0, 2'd0, 32'h0,        32'h0});
    vecs.push_back('{1'b0, 2'd1, 32'h0,        32'd12499});
    vecs.push_back('{1'b0, 2'd2, 32'h0,        32'd4999999});
    vecs.push_back('{1'b0, 2'd3, 32'h0,        32'd1});
    vecs.push_back('{1'b1, 2'd1, 32'hFFFF1234, 32'h1234});
    vecs.push_back('{1'b1, 2'd2, 32'hFFFFFFFF, 32'hFFFFFF});
    vecs.push_back('{1'b1, 2'd3, 32'h1FF,      32'hFF});
    vecs.push_back('{1'b1, 2'd0, 32'h8,        MASK_RB});
    vecs.push_back('{1'b1, 2'd0, 32'h3,        32'h0});
    vecs.push_back('{1'b1, 2'd0, 32'h4,        32'h0});
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].addr, d);
      chk($sformatf("vec%0d_read", i), d, vecs[i].exp);
      chk($sformatf("vec%0d_buzz", i), 32'(buzz_out), 32'h0);
    end

    // Two beeps of period-8 tone, 20 on / 20 off, done after exactly 80 cycles.
    program_start(3, 19, 2);
    check_from(3, 19, 2, 0, 84);

    // Continuous mode, then stop.
    program_start(2, 5, 0);
    check_from(2, 5, 0, 0, 1000);
    wr(2'd0, 32'h2);
    chk("stop_buzz", 32'(buzz_out), 32'h0);
    rd(2'd0, d);
    chk("stop_status", d, 32'h0);

    // Enable dropped mid-ON, then start ignored while disabled.
    program_start(1, 9, 1);
    step(3);
    enable = 1'b0;
    step(1);
    chk("en0_buzz", 32'(buzz_out), 32'h0);
    rd(2'd0, d);
    chk("en0_status", d, 32'h100);
    wr(2'd0, 32'h1);
    step(2);
    chk("en0_start_buzz", 32'(buzz_out), 32'h0);
    rd(2'd0, d);
    chk("en0_start_status", d, 32'h100);
    enable = 1'b1;

    // Restart in the middle of OFF.
    program_start(1, 9, 3);
    step(15);
    chk("mid_off_buzz", 32'(buzz_out), 32'h0);
    wr(2'd0, 32'h1);
    check_from(1, 9, 3, 0, 25);
    wr(2'd0, 32'h2);

    // Shrinking HALF_PERIOD below the running count lets the tone counter wrap.
    program_start(10, 200, 1);
    step(6);
    wr(2'd1, 32'd2);
    for (int k = 0; k < 40; k++) begin
      chk("hp_wrap_buzz", 32'(buzz_out), 32'h1);
      step(1);
    end
    wr(2'd0, 32'h2);

    // Completion interrupt and clear-done.
    wr(2'd1, 32'd0); wr(2'd2, 32'd1); wr(2'd3, 32'd1); wr(2'd0, 32'h9);
    step(4);
    rd(2'd0, d);
    chk("irq_done_status", d, 32'h102 | MASK_RB);
    chk("irq_lag", 32'(irq), 32'h0);
    step(1);
    chk("irq_set", 32'(irq), 32'(IRQ_ON));
    wr(2'd0, 32'h4);
    rd(2'd0, d);
    chk("clr_done_status", d, 32'h100);
    chk("irq_after_clr", 32'(irq), 32'(IRQ_ON));
    step(1);
    chk("irq_cleared", 32'(irq), 32'h0);

    // Randomized programs against the model; stop afterwards.
    for (int it = 0; it < 8; it++) begin
      h  = $urandom_range(0, 4);
      g  = $urandom_range(0, 12);
      bc = $urandom_range(0, 3);
      n  = (bc == 0) ? 60 : 2 * bc * (g + 1) + 4;
      program_start(h, g, bc);
      check_from(h, g, bc, 0, n);
      wr(2'd0, 32'h2);
      chk("rand_stop_buzz", 32'(buzz_out), 32'h0);
      rd(2'd0, d);
      chk("rand_stop_status", d, (bc == 0) ? 32'h0 : 32'h102);
    end

    // Reset mid-sequence wins over a simultaneous write.
    program_start(2, 5, 2);
    step(4);
    reset = 1'b1;
    address = 2'd1; writedata = 32'd7; chipselect = 1'b1; write_n = 1'b0;
    step(1);
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    chk("rst_buzz", 32'(buzz_out), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    rd(2'd0, d); chk("rst_status", d, 32'h0);
    rd(2'd1, d); chk("rst_half_period", d, 32'd12499);
    rd(2'd2, d); chk("rst_gate", d, 32'd4999999);
    rd(2'd3, d); chk("rst_beep_count", d, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/buzzer_seq.md
BUZZER_SEQ -- requirements
Module: buzzer_seq

Interface
REQ-001 Parameter: DIV_W, 16, width of the tone half-period register.
REQ-002 Parameter: GATE_W, 24, width of the beep on/off duration register.
REQ-003 Parameter: CNT_W, 8, width of the beep-count register.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high. Ports are clk and reset.
REQ-005 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-006 Port: reset  in  1  synchronous active-high reset.
REQ-007 Port: enable  in  1  master enable, driven by the upstream buzzer PIO out_port; 0 forces idle and silence.
REQ-008 Port: address  in  2  Avalon-MM slave word address.
REQ-009 Port: chipselect  in  1  slave select.
REQ-010 Port: write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
REQ-011 Port: writedata  in  32  write data.
REQ-012 Port: readdata  out  32  combinational read mux (read latency 0); unused bits read 0.
REQ-013 Port: buzz_out  out  1  square-wave drive to the buzzer pin.
REQ-014 Port: irq  out  1  completion interrupt (see Configuration).

Function
REQ-015 The register map SHALL be: addr0 CTRL/STATUS; addr1 HALF_PERIOD[DIV_W-1:0]; addr2 GATE[GATE_W-1:0]; addr3 BEEP_COUNT[CNT_W-1:0].
REQ-016 CTRL write bits SHALL be: bit0 start, bit1 stop, bit2 clear done, bit3 irq_mask (stored).
REQ-017 STATUS read SHALL be: bit0 busy, bit1 done, bit3 irq_mask, bits[8+CNT_W-1:8] beeps_left.
REQ-018 The FSM SHALL have states IDLE, ON and OFF; busy=1 in ON and OFF.
REQ-019 A start write seen at edge N with enable=1 SHALL put the FSM in ON with buzz_out=1 after edge N; it SHALL clear tone_cnt and gate_cnt, load beeps_left from BEEP_COUNT, and clear done.
REQ-020 A start write while busy SHALL restart the sequence as in REQ-019.
REQ-021 A start write with enable=0 SHALL be ignored.
REQ-022 In ON, tone_cnt SHALL increment each cycle; when tone_cnt==HALF_PERIOD, buzz_out SHALL toggle and tone_cnt SHALL clear, giving a period of 2*(HALF_PERIOD+1) cycles; HALF_PERIOD=0 SHALL toggle every cycle.
REQ-023 ON and OFF SHALL each last GATE+1 cycles, counted by gate_cnt, which clears on each state change.
REQ-024 ON->OFF SHALL force buzz_out=0; buzz_out SHALL be 0 in OFF and IDLE.
REQ-025 At the end of OFF with BEEP_COUNT!=0 and beeps_left==1, the FSM SHALL go to IDLE and set done (sticky); otherwise beeps_left SHALL decrement and the FSM SHALL return to ON with buzz_out=1.
REQ-026 BEEP_COUNT=0 SHALL mean continuous beeping; beeps_left SHALL stay 0 and the sequence SHALL end only by stop or enable=0.
REQ-027 A stop write SHALL force IDLE and buzz_out=0 on the next edge without setting done; if start and stop are written together, stop wins.
REQ-028 enable=0 in any state SHALL force IDLE and buzz_out=0 on the next edge without setting done.
REQ-029 Writes to HALF_PERIOD or GATE while busy SHALL take effect at the next compare; if the counter is already past the new value, it SHALL run on and wrap at 2^W.
REQ-030 A clear-done write SHALL clear done; if set-done and clear-done occur in the same cycle, set wins.

Reset
REQ-031 On reset the block SHALL set: state=IDLE, buzz_out=0, done=0, irq_mask=0, irq=0, tone_cnt=0, gate_cnt=0, beeps_left=0, HALF_PERIOD=12499, GATE=4999999, BEEP_COUNT=1.
REQ-032 Reset asserted mid-sequence SHALL take priority over all writes and enable, and takes effect at the next edge.

Configuration
REQ-033 Macro BUZZER_SEQ_IRQ_EN defined: irq SHALL be a registered output equal to done & irq_mask (one-cycle lag from done/mask); irq_mask SHALL be writable and readable.
REQ-034 Macro BUZZER_SEQ_IRQ_EN undefined: the irq port SHALL remain and be tied 0; irq_mask SHALL read 0 and ignore writes.

Verification
REQ-035 Set HALF_PERIOD=3, GATE=19, BEEP_COUNT=2, then start -> buzz_out is a period-8 wave for 20 cycles, low for 20, repeats once, then done=1 and busy=0 after exactly 80 cycles.
REQ-036 Set BEEP_COUNT=0, start, wait 1000 cycles -> busy=1 and beeps_left=0 throughout; write stop -> IDLE and buzz_out=0 on the next edge, done=0.
REQ-037 Drop enable to 0 mid-ON -> buzz_out=0 and busy=0 next edge; start while enable=0 -> no effect.
REQ-038 Write start and stop (CTRL=0x3) in the same cycle while IDLE -> the FSM stays IDLE; restart mid-OFF with BEEP_COUNT=3 -> ON next edge with beeps_left=3.
REQ-039 With the IRQ macro defined and irq_mask=1: sequence completes -> irq=1 one cycle after done; write CTRL=0x4 -> done=0 and irq=0 one cycle later. With the macro undefined -> irq stays 0 throughout.
REQ-040 Assert reset mid-sequence -> after the next edge all registers read their reset values and buzz_out=0.
